// File: rtl/chasy_pkg.sv
// ============================================================================
// Module      : chasy_pkg
// Description : Shared types and constants for the clock/timer display path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chasy_pkg;

  // Time word, binary fields, packed {hour, min, sec}
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } hms_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  localparam logic [1:0] SETUP_OFF  = 2'd0;
  localparam logic [1:0] SETUP_HOUR = 2'd1;
  localparam logic [1:0] SETUP_MIN  = 2'd2;
  localparam logic [1:0] SETUP_SEC  = 2'd3;

  localparam logic [1:0] MODE_TIMER = 2'd1;

endpackage

`default_nettype wire

// File: rtl/hms_dec.sv
// ============================================================================
// Module      : hms_dec
// Description : Combinational borrow-decrement of an hms_t with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_dec
  import chasy_pkg::*;
(
  input  hms_t i_val,
  output hms_t o_val,
  output logic o_is_zero
);

  always_comb begin
    o_val = i_val;
    if (i_val.sec != 8'd0) begin
      o_val.sec = i_val.sec - 8'd1;
    end else begin
      o_val.sec = 8'd59;
      if (i_val.min != 8'd0) begin
        o_val.min = i_val.min - 8'd1;
      end else begin
        o_val.min  = 8'd59;
        o_val.hour = i_val.hour - 8'd1;
      end
    end
  end

  assign o_is_zero = (o_val == hms_t'(24'd0));

endmodule

`default_nettype wire

// File: rtl/timer_countdown.sv
// ============================================================================
// Module      : timer_countdown
// Description : 1 Hz countdown timer with start/pause, field setup and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_countdown
  import chasy_pkg::*;
#(
  parameter int HOUR_MAX      = 23,
  parameter int ALARM_SECONDS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic [1:0]  rezhim,
  input  logic        btn_set,
  input  logic        btn_inc,
  input  logic        btn_start,
  output logic [23:0] data_t,
  output logic [1:0]  setup_rezhim_t,
  output logic [23:0] setup_data_t,
  output logic        alarm
);

  localparam int c_CNT_W = $clog2(ALARM_SECONDS + 1);

  run_state_t         r_state, w_state_nxt;
  hms_t               r_data, w_data_nxt;
  hms_t               r_sdata, w_sdata_nxt;
  logic [1:0]         r_mode, w_mode_nxt;
  logic               r_alarm, w_alarm_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  hms_t w_dec;
  logic w_dec_zero;
  logic w_btn_ok, w_set, w_start, w_inc, w_any_btn;

  hms_dec u_dec (
    .i_val     (r_data),
    .o_val     (w_dec),
    .o_is_zero (w_dec_zero)
  );

  // Priority set > start > inc, all gated by timer mode
  assign w_btn_ok  = (rezhim == MODE_TIMER);
  assign w_set     = w_btn_ok & btn_set;
  assign w_start   = w_btn_ok & btn_start & ~btn_set;
  assign w_inc     = w_btn_ok & btn_inc & ~btn_set & ~btn_start;
  assign w_any_btn = w_set | w_start | w_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sdata_nxt = r_sdata;
    w_mode_nxt  = r_mode;
    w_alarm_nxt = r_alarm;
    w_cnt_nxt   = r_cnt;

    // Tick handling first; an accepted button below overrides its data effect
    if (tick_1hz) begin
      if (r_state == ST_RUN && !w_any_btn) begin
        w_data_nxt = w_dec;
        if (w_dec_zero) begin
          w_state_nxt = ST_DONE;
          w_alarm_nxt = 1'b1;
          w_cnt_nxt   = c_CNT_W'(ALARM_SECONDS);
        end
      end else if (r_state == ST_DONE) begin
        if (r_cnt <= c_CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_alarm_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
    end

    if (w_set) begin
      if (r_state != ST_RUN) begin
        w_state_nxt = ST_IDLE;
        if (r_mode == SETUP_OFF) begin
          w_sdata_nxt = r_data;
          w_mode_nxt  = SETUP_HOUR;
          w_alarm_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_mode == SETUP_SEC) begin
          w_data_nxt = r_sdata;
          w_mode_nxt = SETUP_OFF;
        end else begin
          w_mode_nxt = r_mode + 2'd1;
        end
      end
    end else if (w_start) begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (r_data != hms_t'(24'd0) && r_mode == SETUP_OFF) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: w_state_nxt = ST_PAUSE;
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_alarm_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_inc) begin
      case (r_mode)
        SETUP_HOUR: w_sdata_nxt.hour = (r_sdata.hour >= 8'(HOUR_MAX)) ? 8'd0 : r_sdata.hour + 8'd1;
        SETUP_MIN:  w_sdata_nxt.min  = (r_sdata.min >= 8'd59) ? 8'd0 : r_sdata.min + 8'd1;
        SETUP_SEC:  w_sdata_nxt.sec  = (r_sdata.sec >= 8'd59) ? 8'd0 : r_sdata.sec + 8'd1;
        default:    w_sdata_nxt = r_sdata;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_sdata <= '0;
      r_mode  <= SETUP_OFF;
      r_alarm <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sdata <= w_sdata_nxt;
      r_mode  <= w_mode_nxt;
      r_alarm <= w_alarm_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign data_t         = r_data;
  assign setup_data_t   = r_sdata;
  assign setup_rezhim_t = r_mode;
  assign alarm          = r_alarm;

endmodule

`default_nettype wire
